gcd_lcm_coproc: RTL and testbench

Parametrised multi-cycle GCD/LCM coprocessor that succeeds the fixed 8-bit GCD/LCM coprocessor. The operand width is generic, the result is 2×WIDTH so that LCM cannot overflow, and iteration count is bounded by binary (Stein) GCD. Sits beside the RISC-V core as a start/done-handshaked functional unit; the core launches an operation and polls or waits on done.

---
 rtl/coproc_pkg.sv | 20 ++
 rtl/stein_gcd_step.sv | 42 ++++
 rtl/gcd_lcm_coproc.sv | 216 +++++++++++++++++++++
 tb/tb_gcd_lcm_coproc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared types for the GCD/LCM coprocessor.
//   op_e    : operation select captured on an accepted start
//   state_e : sequencing states of the top-level FSM
package coproc_pkg;

  typedef enum logic {
    OP_GCD = 1'b0,
    OP_LCM = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    GCD_RUN = 3'd2,
    LCM_DIV = 3'd3,
    LCM_MUL = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/stein_gcd_step.sv
// One combinational iteration of binary (Stein) GCD.
//   u, v      : current operands (both nonzero while iterating)
//   k         : count of common factors of two removed so far
//   u_nxt, v_nxt, k_nxt : operands/count after this step
//   finished  : u == v, so gcd = u << k and the outputs equal the inputs
module stein_gcd_step #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [CNT_W-1:0] k,
  output logic [WIDTH-1:0] u_nxt,
  output logic [WIDTH-1:0] v_nxt,
  output logic [CNT_W-1:0] k_nxt,
  output logic             finished
);

  // Prioritised Stein update; subtraction only ever takes the larger minus the smaller.
  always_comb begin
    u_nxt    = u;
    v_nxt    = v;
    k_nxt    = k;
    finished = 1'b0;
    if (u == v) begin
      finished = 1'b1;
    end else if (!u[0] && !v[0]) begin
      u_nxt = u >> 1;
      v_nxt = v >> 1;
      k_nxt = k + CNT_W'(1);
    end else if (!u[0]) begin
      u_nxt = u >> 1;
    end else if (!v[0]) begin
      v_nxt = v >> 1;
    end else if (u > v) begin
      u_nxt = (u - v) >> 1;
    end else begin
      v_nxt = (v - u) >> 1;
    end
  end

endmodule

// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM coprocessor with a start/done handshake.
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   start          : launch request, honoured only in IDLE or DONE
//   x0, y0, Op     : operands and operation, captured on an accepted start
//   busy           : operation in flight
//   Done           : level, result valid until the next accepted start
//   result         : zero-extended GCD or full-width LCM
//   zero_in        : a captured operand was zero (valid with Done)
// GCD uses Stein iterations; LCM then computes (A / g) * B with a
// restoring divider and a shift-add multiplier, each WIDTH cycles.
module gcd_lcm_coproc
  import coproc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   y0,
  input  logic               Op,
  output logic               busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero_in
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     u_q, u_d, v_q, v_d;   // Stein operands; reused as dividend/quotient and multiplier
  logic [CNT_W-1:0]     k_q, k_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]     g_q, g_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic                 busy_q, busy_d, done_q, done_d, zero_in_q, zero_in_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     step_u_s, step_v_s, g_shift_s;
  logic [CNT_W-1:0]     step_k_s;
  logic                 step_finished_s;
  logic [WIDTH:0]       rem_shift_s;
  logic                 rem_fits_s;
  logic [2*WIDTH-1:0]   acc_sum_s;

  stein_gcd_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .u        (u_q),
    .v        (v_q),
    .k        (k_q),
    .u_nxt    (step_u_s),
    .v_nxt    (step_v_s),
    .k_nxt    (step_k_s),
    .finished (step_finished_s)
  );

  // The true gcd never exceeds either operand, so the shifted value fits WIDTH bits.
  assign g_shift_s = u_q << k_q;

  // Next-state and datapath logic for every phase of the operation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    u_d       = u_q;
    v_d       = v_q;
    k_d       = k_q;
    g_d       = g_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;
    zero_in_d = zero_in_q;
    // Remainder stays below g, so its top bit is free to take the next dividend bit.
    rem_shift_s = {rem_q[WIDTH-1:0], u_q[WIDTH-1]};
    rem_fits_s  = (rem_shift_s >= {1'b0, g_q});
    acc_sum_s   = acc_q + (v_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d       = x0;
          b_d       = y0;
          op_d      = op_e'(Op);
          done_d    = 1'b0;
          busy_d    = 1'b1;
          result_d  = '0;
          zero_in_d = 1'b0;
          state_d   = CHECK;
        end else begin
          state_d = state_q;
        end
      end
      CHECK: begin
        if ((a_q == '0) || (b_q == '0)) begin
          zero_in_d = 1'b1;
          result_d  = (op_q == OP_GCD) ? {{WIDTH{1'b0}}, a_q | b_q} : '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          u_d     = a_q;
          v_d     = b_q;
          k_d     = '0;
          state_d = GCD_RUN;
        end
      end
      GCD_RUN: begin
        if (step_finished_s) begin
          if (op_q == OP_LCM) begin
            g_d     = g_shift_s;
            u_d     = a_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = LCM_DIV;
          end else begin
            result_d = {{WIDTH{1'b0}}, g_shift_s};
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end else begin
          u_d = step_u_s;
          v_d = step_v_s;
          k_d = step_k_s;
        end
      end
      LCM_DIV: begin
        if (rem_fits_s) begin
          rem_d = rem_shift_s - {1'b0, g_q};
          u_d   = {u_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift_s;
          u_d   = {u_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          mcand_d = {{WIDTH{1'b0}}, u_d};
          v_d     = b_q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = LCM_MUL;
        end else begin
          state_d = LCM_DIV;
        end
      end
      LCM_MUL: begin
        acc_d   = acc_sum_s;
        mcand_d = mcand_q << 1;
        v_d     = v_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          result_d = acc_sum_s;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = LCM_MUL;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_GCD;
      a_q       <= '0;
      b_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      k_q       <= '0;
      g_q       <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      u_q       <= u_d;
      v_q       <= v_d;
      k_q       <= k_d;
      g_q       <= g_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_in_q <= zero_in_d;
    end
  end

  assign busy    = busy_q;
  assign Done    = done_q;
  assign result  = result_q;
  assign zero_in = zero_in_q;

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Self-checking bench for gcd_lcm_coproc at WIDTH = 4, 8 and 16.
// Index 0 -> WIDTH 4, 1 -> WIDTH 8, 2 -> WIDTH 16.
module tb_gcd_lcm_coproc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] x_s, y_s;
  logic        op_s;
  logic [2:0]  start_s;
  wire  [2:0]  busy_s, done_s, zin_s;
  wire  [7:0]  res4;
  wire  [15:0] res8;
  wire  [31:0] res16;

  int n_pass  = 0;
  int n_total = 0;

  gcd_lcm_coproc #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .x0(x_s[3:0]), .y0(y_s[3:0]),
    .Op(op_s), .busy(busy_s[0]), .Done(done_s[0]), .result(res4), .zero_in(zin_s[0]));
  gcd_lcm_coproc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_s[1]), .x0(x_s[7:0]), .y0(y_s[7:0]),
    .Op(op_s), .busy(busy_s[1]), .Done(done_s[1]), .result(res8), .zero_in(zin_s[1]));
  gcd_lcm_coproc #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start_s[2]), .x0(x_s), .y0(y_s),
    .Op(op_s), .busy(busy_s[2]), .Done(done_s[2]), .result(res16), .zero_in(zin_s[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    longint      res;
    logic        zin;
  } vec_t;

  function automatic int width_of(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 8 : 16);
  endfunction

  function automatic longint res_of(input int idx);
    case (idx)
      0:       return longint'({24'd0, res4});
      1:       return longint'({16'd0, res8});
      default: return longint'(res16);
    endcase
  endfunction

  // Reference model: Euclid's gcd and lcm = a*b/gcd, zero operands handled directly.
  function automatic longint ref_gcd(input longint a, input longint b);
    longint t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic longint ref_res(input longint a, input longint b, input logic op);
    if (!op) return ref_gcd(a, b);
    if (a == 0 || b == 0) return 0;
    return (a * b) / ref_gcd(a, b);
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_le(input string name, input longint got, input longint lim);
    n_total++;
    if (got <= lim) n_pass++;
    else $display("FAIL %s: got %0d limit %0d", name, got, lim);
  endtask

  // Present operands at the falling edge; returns 1 ns after the accept edge.
  task automatic start_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic op);
    @(negedge clk);
    x_s = a;
    y_s = b;
    op_s = op;
    start_s[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_s[idx] = 1'b0;
  endtask

  // Latency counts rising edges starting with the accept edge; bounded wait.
  task automatic wait_done(input int idx, input int lat0, output int lat);
    lat = lat0;
    while (!done_s[idx] && lat < 120) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", longint'(done_s[idx]), 1);
  endtask

  task automatic run_vec(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input longint exp_res, input logic exp_zin);
    int lat;
    int w;
    w = width_of(idx);
    start_op(idx, a, b, op);
    wait_done(idx, 1, lat);
    check("result", res_of(idx), exp_res);
    check("zero_in", longint'(zin_s[idx]), longint'(exp_zin));
    check("busy_after", longint'(busy_s[idx]), 0);
    if (exp_zin) check("lat_zero", lat, 2);
    else if (op) check_le("lat_lcm", lat, 4*w + 3);
    else check_le("lat_gcd", lat, 2*w + 3);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    logic [15:0] a, b, mask;
    logic op;
    int nops;

    vecs[0] = '{16'd12,  16'd18,  1'b0, 64'd6,     1'b0};
    vecs[1] = '{16'd12,  16'd18,  1'b1, 64'd36,    1'b0};
    vecs[2] = '{16'd255, 16'd254, 1'b1, 64'd64770, 1'b0};
    vecs[3] = '{16'd0,   16'd45,  1'b0, 64'd45,    1'b1};
    vecs[4] = '{16'd0,   16'd45,  1'b1, 64'd0,     1'b1};
    vecs[5] = '{16'd0,   16'd0,   1'b0, 64'd0,     1'b1};
    vecs[6] = '{16'd21,  16'd14,  1'b0, 64'd7,     1'b0};
    vecs[7] = '{16'd1,   16'd255, 1'b1, 64'd255,   1'b0};
    vecs[8] = '{16'd128, 16'd64,  1'b0, 64'd64,    1'b0};
    vecs[9] = '{16'd255, 16'd255, 1'b1, 64'd255,   1'b0};

    reset   = 1'b0;
    start_s = 3'b000;
    x_s     = 16'd0;
    y_s     = 16'd0;
    op_s    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy_s[1]), 0);
    check("rst_done", longint'(done_s[1]), 0);
    check("rst_result", res_of(1), 0);
    check("rst_zero_in", longint'(zin_s[1]), 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors at WIDTH 8
    for (int i = 0; i < 10; i++)
      run_vec(1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zin);

    // Start while running is ignored
    start_op(1, 16'd12, 16'd18, 1'b1);
    @(posedge clk);
    @(negedge clk);
    x_s = 16'd7;
    y_s = 16'd7;
    op_s = 1'b0;
    start_s[1] = 1'b1;
    @(posedge clk);
    #1;
    start_s[1] = 1'b0;
    wait_done(1, 3, lat);
    check("ignored_start_result", res_of(1), 36);
    check_le("ignored_start_lat", lat, 35);

    // New start from DONE drops Done on the accept edge
    start_op(1, 16'd7, 16'd7, 1'b0);
    check("restart_done_low", longint'(done_s[1]), 0);
    check("restart_busy_high", longint'(busy_s[1]), 1);
    wait_done(1, 1, lat);
    check("restart_result", res_of(1), 7);

    // Asynchronous reset in the middle of the multiply phase
    start_op(1, 16'd12, 16'd18, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("mid_busy", longint'(busy_s[1]), 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_done", longint'(done_s[1]), 0);
    check("abort_busy", longint'(busy_s[1]), 0);
    check("abort_result", res_of(1), 0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(1, 16'd21, 16'd14, 1'b0, 7, 1'b0);

    // Randomised sweep against the reference model
    for (int idx = 0; idx < 3; idx++) begin
      mask = (idx == 0) ? 16'h000F : ((idx == 1) ? 16'h00FF : 16'hFFFF);
      nops = (idx == 0) ? 600 : ((idx == 1) ? 300 : 500);
      for (int n = 0; n < nops; n++) begin
        a  = 16'($urandom) & mask;
        b  = 16'($urandom) & mask;
        if ($urandom_range(0, 7) == 0) a = 16'd0;
        if ($urandom_range(0, 7) == 0) b = 16'd0;
        op = 1'($urandom_range(0, 1));
        run_vec(idx, a, b, op, ref_res(longint'(a), longint'(b), op),
                (a == 16'd0) || (b == 16'd0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
